// File: rtl/tea_key_search.sv
// Key-search scheduler driving one TEA decryption core over an inclusive 48-bit key range.
// Define TEA_KS_SCAN_ALL_EN to scan past hits to key_hi instead of stopping at the first hit.
module tea_key_search #(
  parameter int unsigned ROUNDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        go,
  input  logic        abort,
  input  logic [63:0] data_in,
  input  logic [47:0] key_lo,
  input  logic [47:0] key_hi,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [47:0] key_found,
  output logic [15:0] hit_cnt,
  output logic [47:0] cur_key,
  output logic        core_ena,
  output logic        core_start,
  output logic [63:0] core_data,
  output logic [47:0] core_key,
  input  logic        core_valid
);

`ifdef TEA_KS_SCAN_ALL_EN
  localparam bit SCAN_ALL = 1'b1;
`else
  localparam bit SCAN_ALL = 1'b0;
`endif

  localparam logic [5:0] LAST_WAIT = 6'(ROUNDS - 1);
  localparam logic [5:0] DRAIN_END = 6'(ROUNDS);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CHECK, DONE, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [47:0] key_q, key_d;
  logic [47:0] hi_q, hi_d;
  logic [63:0] data_q, data_d;
  logic        found_q, found_d;
  logic [47:0] kf_q, kf_d;
  logic [15:0] hits_q, hits_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      hi_q    <= '0;
      data_q  <= '0;
      found_q <= 1'b0;
      kf_q    <= '0;
      hits_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      found_q <= found_d;
      kf_q    <= kf_d;
      hits_q  <= hits_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    hi_d    = hi_q;
    data_d  = data_q;
    found_d = found_q;
    kf_d    = kf_q;
    hits_d  = hits_q;
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            data_d  = data_in;
            hi_d    = key_hi;
            key_d   = key_lo;
            found_d = 1'b0;
            kf_d    = '0;
            hits_d  = '0;
            state_d = (key_lo > key_hi) ? DONE : LAUNCH;
          end
        end
        LAUNCH: begin
          cnt_d   = '0;
          state_d = abort ? DRAIN : WAIT;
        end
        WAIT: begin
          cnt_d = cnt_q + 6'd1;
          if (abort)                   state_d = DRAIN;
          else if (cnt_q == LAST_WAIT) state_d = CHECK;
        end
        CHECK: begin
          // Counter keeps running so an abort here drains relative to the last launch.
          cnt_d = cnt_q + 6'd1;
          if (abort) begin
            state_d = DRAIN;
          end else begin
            if (core_valid) begin
              found_d = 1'b1;
              kf_d    = key_q;
              if (hits_q != '1) hits_d = hits_q + 16'd1;
            end
            // End compare precedes the increment so key_hi of all-ones cannot wrap.
            if (key_q == hi_q || (core_valid && !SCAN_ALL)) begin
              state_d = DONE;
            end else begin
              key_d   = key_q + 48'd1;
              state_d = LAUNCH;
            end
          end
        end
        DONE: state_d = IDLE;
        DRAIN: begin
          if (cnt_q >= DRAIN_END) state_d = IDLE;
          else                    cnt_d   = cnt_q + 6'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign core_start = (state_q == LAUNCH);
  assign found      = found_q;
  assign key_found  = kf_q;
  assign hit_cnt    = hits_q;
  assign cur_key    = key_q;
  assign core_key   = key_q;
  assign core_data  = data_q;
  assign core_ena   = ena;

endmodule

// File: doc/tea_key_search.md
# tea_key_search

Key-search scheduler that sequences one TEA decryption core over a range of 48-bit candidate keys for a single 64-bit ciphertext block. It launches one decryption per candidate, waits the core's fixed round latency, samples the core's plaintext-match flag, and reports the first matching key. It sits between the host command/status registers and one decryption core, and is the only agent that drives the core's start, key and data inputs.

## Interface
- ROUNDS, 32, core decryption rounds; the wait length per candidate.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  global clock-enable; forwarded unchanged on core_ena.
- go  in  1  start a search; accepted only in IDLE.
- abort  in  1  cancel the running search.
- data_in  in  64  ciphertext, latched on accepted go.
- key_lo  in  48  first candidate, latched on accepted go.
- key_hi  in  48  last candidate (inclusive), latched on accepted go.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a search ends; not pulsed after abort.
- found  out  1  at least one hit in the last completed search; held until next accepted go.
- key_found  out  48  matching key; held until next accepted go.
- hit_cnt  out  16  number of hits in the last search; saturates at 16'hFFFF.
- cur_key  out  48  candidate currently in flight.
- core_ena  out  1  equals ena.
- core_start  out  1  one-cycle launch strobe to the core.
- core_data  out  64  latched ciphertext.
- core_key  out  48  equals cur_key.
- core_valid  in  1  core plaintext-match flag; meaningful only in CHECK.

## Operation
- States: IDLE, LAUNCH, WAIT, CHECK, DONE, DRAIN. A 6-bit wait counter and a 48-bit candidate register.
- IDLE: on go, latch data_in, key_lo and key_hi. Set cur_key to key_lo. Clear found, key_found and hit_cnt.
  - If key_lo > key_hi, the range is empty: go to DONE without any launch.
  - Otherwise go to LAUNCH.
- LAUNCH: core_start=1 for exactly this cycle. Clear the wait counter. Go to WAIT.
- WAIT: increment the counter each cycle. After ROUNDS WAIT cycles, go to CHECK.
- CHECK: sample core_valid.
  - On a hit: set found, load key_found with cur_key, and increment hit_cnt (saturating).
  - If cur_key == key_hi, or on a hit with the scan-all feature compiled out: go to DONE.
  - Otherwise: increment cur_key and go to LAUNCH.
  - The end compare is done before the increment, so key_hi=48'hFFFF_FFFF_FFFF never wraps cur_key.
- DONE: done=1 for one cycle, then IDLE.
- abort:
  - In LAUNCH, WAIT or CHECK: go to DRAIN. The wait counter continues so the core can return to its idle state. DRAIN lasts until ROUNDS+1 cycles have passed since the last launch, then goes to IDLE.
  - found, key_found and hit_cnt keep whatever values they had when the abort occurred.
  - abort in IDLE, DONE or DRAIN is ignored.
  - If abort and a hit occur in the same CHECK cycle, abort wins: DRAIN, and the hit is not recorded.
- go outside IDLE is ignored.
- ena=0 freezes all state, counters and outputs. Pulses (done, core_start) stretch while ena is low.
- Reset values: all outputs are 0 except core_ena (follows ena). State is IDLE, all registers are 0.

## Timing
- Let LAUNCH be cycle S (core samples start at the end of S).
- WAIT occupies S+1..S+ROUNDS. The core is in its final-round state at S+ROUNDS+1.
- CHECK is at S+ROUNDS+1 = S+33. The next LAUNCH is at S+34.
- Throughput is one candidate per ROUNDS+2 = 34 enabled cycles.
- From go accepted at cycle G:
  - first LAUNCH at G+1;
  - single-candidate search: done pulses at G+35.
  - N-candidate miss: done pulses at G+1+34·N.
- found and key_found update on the clock edge ending CHECK, so they are visible during DONE.

## Configuration
- TEA_KS_SCAN_ALL_EN defined:
  - The search continues past hits to key_hi.
  - key_found holds the last hit.
  - hit_cnt counts all hits, saturating.
- TEA_KS_SCAN_ALL_EN undefined:
  - The search stops at the first hit.
  - hit_cnt is 0 or 1.

## Test plan
- The bench uses a core model that asserts core_valid in CHECK when the launched key is 48'h1234_5678_9ABC.
- key_lo=key_hi=48'h1234_5678_9ABC, go at G -> one core_start at G+1; done at G+35; found=1; key_found=48'h1234_5678_9ABC; hit_cnt=1.
- key_lo=48'h0, key_hi=48'h3 (no hit) -> four core_start pulses 34 cycles apart; done at G+137; found=0; hit_cnt=0.
- key_lo=48'h1234_5678_9ABA, key_hi=48'h1234_5678_9AC0 -> stop-first build: done at G+103 after 3 launches. TEA_KS_SCAN_ALL_EN build: 7 launches; hit_cnt=1; done at G+239.
- key_lo=48'h5, key_hi=48'h4 -> no core_start; done at G+1; found=0; busy high for one cycle.
- key_lo=key_hi=48'hFFFF_FFFF_FFFF -> exactly one launch; cur_key stays 48'hFFFF_FFFF_FFFF; done at G+35.
- abort at S+10 during WAIT -> no done pulse; busy falls after S+33; a go issued during DRAIN is ignored; a go after busy falls is accepted.
- Hold ena=0 for 5 cycles mid-WAIT -> the done pulse is delayed by exactly 5 cycles.
